// File: rtl/mux4_pkg.sv
// Shared types and helpers for the 4-channel collector and its return-path demux.
package mux4_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t rr_next(input sel_t p);
        return p + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way arbiter: rotating priority from ptr, or fixed
// priority (ch0 highest) when MUX4_FIXED_PRIO_EN is defined.
import mux4_pkg::*;

module rr_arb4 (
    input  logic [CH_NUM-1:0] req,
    input  sel_t              ptr,
    output logic [CH_NUM-1:0] gnt_onehot,
    output sel_t              gnt_idx
);

    sel_t base;
    sel_t idx;
    logic found;

`ifdef MUX4_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = ptr;
`endif

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        idx        = '0;
        found      = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = base + sel_t'(k);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_collect.sv
// Four-channel valid/ready collector with arbitration and a registered output.
// Build option: MUX4_FIXED_PRIO_EN selects fixed priority instead of round-robin.
import mux4_pkg::*;

module mux4_rr_collect #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM-1:0]        in_valid,
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    output logic [CH_NUM-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output sel_t                     out_sel,
    input  logic                     out_ready
);

    logic [CH_NUM-1:0] gnt_onehot;
    sel_t              gnt_idx;
    sel_t              ptr;
    logic              can_load;
    logic              load;

    rr_arb4 u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Register can accept when empty or draining this cycle.
    assign can_load = !out_valid || out_ready;
    assign load     = can_load && (|in_valid);
    assign in_ready = rst_n ? (gnt_onehot & {CH_NUM{can_load}}) : '0;

`ifdef MUX4_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= rr_next(gnt_idx);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_sel   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_collect.sv
// Directed bench for mux4_rr_collect with hand-computed expectations.
module tb_mux4_rr_collect;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    mux4_rr_collect #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel,
                           input logic [7:0] data);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
        chk({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        // single channel 0 word
        rst_n    = 1'b1;
        in_valid = 4'b0001;
        in_data  = 32'h000000A5;
        #1;
        chk("t1_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("t1", 2'd0, 8'hA5);

        // all valid, ptr now 1: 1,2,3,0,1 back to back
        in_valid = 4'hF;
        in_data  = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("t2", seq[i], 8'h10 + 8'(seq[i]));
        end

        // backpressure holding ch1 word
        out_ready = 1'b0;
        #1;
        chk("t3_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("t3_hold", 2'd1, 8'h11);
            chk("t3_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release", 32'(in_ready), 32'b0100);
        tick();
        chk_out("t3_next", 2'd2, 8'h12);

        // ptr=3, only ch1/ch3 valid: ch3 then wrap to ch1
        in_valid = 4'b1010;
        #1;
        chk("t4_ready3", 32'(in_ready), 32'b1000);
        tick();
        chk_out("t4_a", 2'd3, 8'h13);
        chk("t4_ready1", 32'(in_ready), 32'b0010);
        tick();
        chk_out("t4_b", 2'd1, 8'h11);

        // drain without load holds data/sel
        in_valid = 4'b0000;
        tick();
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_sel", 32'(out_sel), 32'd1);
        chk("t5_data", 32'(out_data), 32'h11);

        // load ch1 leaves ptr=2, then async reset mid-cycle
        in_valid = 4'b0010;
        tick();
        chk_out("t6_pre", 2'd1, 8'h11);
        in_valid  = 4'hF;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_sel", 32'(out_sel), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6_first", 32'(in_ready), 32'b0001);
        tick();
        chk_out("t6_g0", 2'd0, 8'h10);
        tick();
        chk_out("t6_g1", 2'd1, 8'h11);

        // ch0 and ch2 contending, ptr now 2
        in_valid = 4'b0101;
`ifdef MUX4_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t7_fixed", 2'd0, 8'h10);
        end
`else
        tick();
        chk_out("t7_a", 2'd2, 8'h12);
        tick();
        chk_out("t7_b", 2'd0, 8'h10);
        tick();
        chk_out("t7_c", 2'd2, 8'h12);
        tick();
        chk_out("t7_d", 2'd0, 8'h10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
